// File: rtl/ksa_sub_pipe_if.sv
// Operand/result handshake bundle for the pipelined Kogge-Stone subtractor.
// Latency: none; wires only.
// Backpressure: in_ready/out_ready carry the elastic valid-ready handshake.
interface ksa_sub_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;
    logic             lt_s;
    logic             ovf;

    // Producer/consumer side: drives operands and accepts results.
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, zero, lt_s, ovf
    );

    // Subtractor side.
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, zero, lt_s, ovf
    );
endinterface

// File: rtl/ksa_sub_pipe.sv
// Pipelined Kogge-Stone subtractor/comparator: diff = a + ~b + 1 with borrow, zero, lt_s, ovf.
// Latency: 3 register stages (result valid after the third edge counting the accepting one).
// Backpressure: elastic valid/ready, each stage loads when empty or draining; in_ready is combinational from out_ready.
module ksa_sub_pipe #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    ksa_sub_pipe_if.slave  bus
);
    localparam int L   = $clog2(WIDTH);
    localparam int LA  = (L + 1) / 2;   // prefix levels done in stage 2, rest in stage 3
    localparam int MSB = WIDTH - 1;

    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic             am;
        logic             bm;
    } s1_t;

    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] p0;
        logic             am;
        logic             bm;
    } s2_t;

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             borrow;
        logic             zero;
        logic             lt_s;
        logic             ovf;
    } res_t;

    // One Kogge-Stone combine level of span s. Vacated low positions behave
    // as an identity element (g = 0, p = 1) so lower bits pass unchanged.
    function automatic logic [2*WIDTH-1:0] prefix_level(
        input logic [WIDTH-1:0] g,
        input logic [WIDTH-1:0] p,
        input int               s
    );
        logic [WIDTH-1:0] fill;
        logic [WIDTH-1:0] g_n;
        logic [WIDTH-1:0] p_n;
        fill = ~({WIDTH{1'b1}} << s);
        g_n  = g | (p & (g << s));
        p_n  = p & ((p << s) | fill);
        return {g_n, p_n};
    endfunction

    logic v1;
    logic v2;
    logic v3;
    logic adv3;
    logic load1;
    logic load2;
    logic load3;
    logic take;

    s1_t  s1_q;
    s1_t  s1_d;
    s2_t  s2_q;
    s2_t  s2_d;
    res_t res_q;
    res_t res_d;

    // Handshake: a stage may load when it is empty or its content moves on this cycle.
    always_comb begin
        adv3  = v3 & bus.out_ready;
        load3 = !v3 | adv3;
        load2 = !v2 | load3;
        load1 = !v1 | load2;
        take  = bus.in_valid & load1;
    end

    assign bus.in_ready = load1;

    // Stage 1 input: per-bit generate/propagate against the inverted subtrahend.
    always_comb begin
        s1_d    = '0;
        s1_d.g  = bus.a & ~bus.b;
        s1_d.p  = bus.a ^ ~bus.b;
        s1_d.am = bus.a[MSB];
        s1_d.bm = bus.b[MSB];
    end

    // Stage 1 register: captures a new pair only on a real transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1   <= 1'b0;
            s1_q <= '0;
        end else if (load1) begin
            v1 <= take;
            if (take) begin
                s1_q <= s1_d;
            end
        end
    end

    // Stage 2 input: first half of the prefix levels (spans 1 .. 2^(LA-1)).
    always_comb begin
        logic [WIDTH-1:0] g_t;
        logic [WIDTH-1:0] p_t;
        g_t = s1_q.g;
        p_t = s1_q.p;
        for (int k = 0; k < LA; k++) begin
            {g_t, p_t} = prefix_level(g_t, p_t, 1 << k);
        end
        s2_d    = '0;
        s2_d.g  = g_t;
        s2_d.p  = p_t;
        s2_d.p0 = s1_q.p;
        s2_d.am = s1_q.am;
        s2_d.bm = s1_q.bm;
    end

    // Stage 2 register: moves stage 1 content forward when allowed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v2   <= 1'b0;
            s2_q <= '0;
        end else if (load2) begin
            v2 <= v1;
            if (v1) begin
                s2_q <= s2_d;
            end
        end
    end

    // Stage 3 input: remaining prefix levels, carry injection (cin = 1), sum and flags.
    always_comb begin
        logic [WIDTH-1:0] g_t;
        logic [WIDTH-1:0] p_t;
        logic [WIDTH-1:0] c_in;
        logic             carry_out;
        logic             ovf_t;
        g_t = s2_q.g;
        p_t = s2_q.p;
        for (int k = LA; k < L; k++) begin
            {g_t, p_t} = prefix_level(g_t, p_t, 1 << k);
        end
        c_in         = {g_t[MSB-1:0] | p_t[MSB-1:0], 1'b1};
        carry_out    = g_t[MSB] | p_t[MSB];
        res_d        = '0;
        res_d.diff   = s2_q.p0 ^ c_in;
        res_d.borrow = ~carry_out;
        res_d.zero   = ~|res_d.diff;
        ovf_t        = (s2_q.am ^ s2_q.bm) & (s2_q.am ^ res_d.diff[MSB]);
        res_d.ovf    = ovf_t;
        res_d.lt_s   = res_d.diff[MSB] ^ ovf_t;
    end

    // Stage 3 register: the output register; holds steady while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v3    <= 1'b0;
            res_q <= '0;
        end else if (load3) begin
            v3 <= v2;
            if (v2) begin
                res_q <= res_d;
            end
        end
    end

    assign bus.out_valid = v3;
    assign bus.diff      = res_q.diff;
    assign bus.borrow    = res_q.borrow;
    assign bus.zero      = res_q.zero;
    assign bus.lt_s      = res_q.lt_s;
    assign bus.ovf       = res_q.ovf;
endmodule

// File: tb/tb_ksa_sub_pipe.sv
// Self-checking bench for ksa_sub_pipe: directed vectors, backpressure, random stream, reset, 8-bit variant.
// Latency: expects results after three edges counting the accepting edge.
// Backpressure: drives out_ready low/random and predicts in_ready from occupancy.
module tb_ksa_sub_pipe;
    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    ksa_sub_pipe_if #(.WIDTH(32)) bus ();
    ksa_sub_pipe_if #(.WIDTH(8))  bus8 ();

    ksa_sub_pipe #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    ksa_sub_pipe #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [35:0] exp;   // {diff, borrow, zero, lt_s, ovf}
        string       name;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    logic [35:0] q[$];
    logic        seen_rdy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] d;
        longint      sd;
        logic        ov;
        d  = x - y;
        sd = longint'($signed(x)) - longint'($signed(y));
        ov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        return {d, (x < y), (d == 32'd0), ($signed(x) < $signed(y)), ov};
    endfunction

    function automatic logic [35:0] out32();
        return {bus.diff, bus.borrow, bus.zero, bus.lt_s, bus.ovf};
    endfunction

    // One isolated pair on an empty pipe with out_ready high; checks latency and result.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.a         = v.a;
        bus.b         = v.b;
        bus.out_ready = 1'b1;
        #1;
        chk({v.name, "/in_ready"}, bus.in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({v.name, "/valid_after_1"}, bus.out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk({v.name, "/valid_after_2"}, bus.out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk({v.name, "/valid_after_3"}, bus.out_valid, 1);
        chk({v.name, "/result"}, out32(), v.exp);
        @(posedge clk);
    endtask

    // One clock cycle of streaming with scoreboard checks on in_ready and results.
    task automatic step(input logic iv, input logic [31:0] av, input logic [31:0] bv,
                        input logic ordy, output logic took);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.a         = av;
        bus.b         = bv;
        bus.out_ready = ordy;
        #1;
        seen_rdy = bus.in_ready;
        chk("in_ready", bus.in_ready, (q.size() < 3) || ordy);
        if (bus.out_valid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_out: got out_valid=1 expected 0");
            end else begin
                chk("stream_result", out32(), q[0]);
                if (ordy) void'(q.pop_front());
            end
        end
        took = iv && bus.in_ready;
        if (took) q.push_back(model(av, bv));
        @(posedge clk);
    endtask

    task automatic drain(input string name);
        logic t;
        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            step(1'b0, 32'd0, 32'd0, 1'b1, t);
        end
        chk(name, q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[8];
        logic [31:0] pa[10];
        logic [31:0] pb[10];
        logic        took;
        logic        saw_full;
        int          issued;
        int          cyc;
        int          idx;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0] = '{32'd5,        32'd3,        {32'd2,        4'b0000}, "5_minus_3"};
        vecs[1] = '{32'd3,        32'd5,        {32'hFFFFFFFE, 4'b1010}, "3_minus_5"};
        vecs[2] = '{32'd0,        32'd1,        {32'hFFFFFFFF, 4'b1010}, "0_minus_1"};
        vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, {32'h00000000, 4'b0100}, "ones_minus_ones"};
        vecs[4] = '{32'h80000000, 32'd1,        {32'h7FFFFFFF, 4'b0011}, "min_minus_1"};
        vecs[5] = '{32'h7FFFFFFF, 32'hFFFFFFFF, {32'h80000000, 4'b1001}, "max_minus_m1"};
        vecs[6] = '{32'h40000000, 32'hC0000000, {32'h80000000, 4'b1001}, "pos_ovf"};
        vecs[7] = '{32'hFFFFFFFB, 32'd3,        {32'hFFFFFFF8, 4'b0010}, "m5_minus_3"};

        bus.in_valid   = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.out_ready  = 1'b1;
        bus8.in_valid  = 1'b0;
        bus8.a         = '0;
        bus8.b         = '0;
        bus8.out_ready = 1'b1;
        seen_rdy       = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst/out_valid", bus.out_valid, 0);
        chk("rst/outputs", out32(), 36'd0);
        chk("rst/in_ready", bus.in_ready, 1);
        @(negedge clk);
        reset = 1'b1;

        // Directed table
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Backpressure: 10 pairs, out_ready low on cycles 4..9
        for (int i = 0; i < 10; i++) begin
            pa[i] = $urandom;
            pb[i] = $urandom;
        end
        issued   = 0;
        cyc      = 0;
        saw_full = 1'b0;
        while ((issued < 10 || cyc < 12) && cyc < 100) begin
            idx = (issued < 10) ? issued : 0;
            step(issued < 10, pa[idx], pb[idx], !(cyc >= 4 && cyc <= 9), took);
            if (!seen_rdy) saw_full = 1'b1;
            if (took) issued++;
            cyc++;
        end
        chk("bp/accepted_all", issued, 10);
        chk("bp/in_ready_fell", saw_full, 1);
        drain("bp/drain_empty");

        // Random stream with random valid/ready
        issued = 0;
        cyc    = 0;
        while (issued < 1000 && cyc < 6000) begin
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = ra;
                1:       rb = ra + 32'd1;
                2:       rb = 32'h80000000;
                default: rb = $urandom;
            endcase
            step($urandom_range(0, 3) != 0, ra, rb, $urandom_range(0, 3) != 0, took);
            if (took) issued++;
            cyc++;
        end
        chk("rand/accepted_all", issued, 1000);
        drain("rand/drain_empty");

        // Reset mid-stream with three pairs in flight
        for (int i = 0; i < 3; i++) step(1'b1, 32'd100 + i, 32'd7, 1'b0, took);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst/out_valid", bus.out_valid, 0);
        chk("mid_rst/outputs", out32(), 36'd0);
        chk("mid_rst/in_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.a        = 32'd1;
        bus.b        = 32'd2;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst/held_valid", bus.out_valid, 0);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        q.delete();
        for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 32'd0, 1'b1, took);
        run_vec('{32'd9, 32'd9, {32'd0, 4'b0100}, "post_rst_9_minus_9"});

        // 8-bit variant
        @(negedge clk);
        bus8.in_valid  = 1'b1;
        bus8.a         = 8'h10;
        bus8.b         = 8'h20;
        bus8.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.in_valid = 1'b0;
        chk("w8/valid_after_1", bus8.out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk("w8/valid_after_2", bus8.out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk("w8/valid_after_3", bus8.out_valid, 1);
        chk("w8/result", {bus8.diff, bus8.borrow, bus8.zero, bus8.lt_s, bus8.ovf}, {8'hF0, 4'b1010});
        @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
